// File: rtl/bounce_emulator.sv
// Purpose : turns a clean level into a bouncing copy; each input change yields a
//           burst of 1 + 2*N_BOUNCE pseudo-random-spaced toggles, then a settle window.
// Latency : first o_lvl transition lands 1 cycle after the input change; bypass is 1 cycle.
// Backpr. : none; the input is sampled every cycle and a new change restarts the burst.
// Ports   : i_clk, i_rst (sync, active high), i_en (1 = emulate, 0 = bypass),
//           i_clr (clear toggle counter), i_lvl (clean level) ->
//           o_lvl (bouncing level, registered), o_busy (BOUNCE or SETTLE),
//           o_toggle_count (o_lvl transitions, wraps), o_state (0 IDLE, 1 BOUNCE, 2 SETTLE).
module bounce_emulator #(
  parameter int          N_BOUNCE = 3,
  parameter int          MIN_SEG  = 4,
  parameter int          DUR_W    = 4,
  parameter int          SETTLE   = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_lvl,
  output logic       o_lvl,
  output logic       o_busy,
  output logic [7:0] o_toggle_count,
  output logic [1:0] o_state
);

  localparam int SEG_W  = $clog2(MIN_SEG + (1 << DUR_W)) + 1;
  localparam int TMR_W  = $clog2(SETTLE) + 1;
  localparam int LEFT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_lfsr, w_lfsr_nxt;
  logic              r_target, w_target_nxt;
  logic              r_lvl, w_lvl_nxt;
  logic [LEFT_W-1:0] r_left, w_left_nxt;
  logic [SEG_W-1:0]  r_seg, w_seg_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [SEG_W-1:0]  w_seg_load;
  logic              w_chg;

  // Galois form, taps x^16+x^14+x^13+x^11; free-running, including bypass.
  assign w_lfsr_nxt = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400)
                                : {1'b0, r_lfsr[15:1]};

  // Counter is preloaded with length-1 so the toggle fires exactly `length`
  // cycles after the load edge.
  assign w_seg_load = SEG_W'(MIN_SEG - 1) + SEG_W'(r_lfsr[DUR_W-1:0]);

  assign w_chg = (i_lvl != r_target);

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_lvl_nxt    = r_lvl;
    w_left_nxt   = r_left;
    w_seg_nxt    = r_seg;
    w_tmr_nxt    = r_tmr;

    if (!i_en) begin
      w_state_nxt  = S_IDLE;
      w_target_nxt = i_lvl;
      w_lvl_nxt    = i_lvl;
    end else if (w_chg) begin
      // Same entry from any state: a change mid-burst abandons the partial
      // burst and reloads the full pair count for the new target.
      w_state_nxt  = S_BOUNCE;
      w_target_nxt = i_lvl;
      w_lvl_nxt    = i_lvl;
      w_left_nxt   = LEFT_W'(2 * N_BOUNCE);
      w_seg_nxt    = w_seg_load;
    end else begin
      case (r_state)
        S_BOUNCE: begin
          if (r_seg == '0) begin
            w_lvl_nxt  = ~r_lvl;
            w_left_nxt = r_left - 1'b1;
            w_seg_nxt  = w_seg_load;
            // Even number of extra toggles, so o_lvl is back at target here.
            if (r_left == LEFT_W'(1)) begin
              w_state_nxt = S_SETTLE;
              w_tmr_nxt   = TMR_W'(SETTLE - 1);
            end
          end else begin
            w_seg_nxt = r_seg - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_tmr == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_tmr_nxt = r_tmr - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Clear wins over a simultaneous transition.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = 8'd0;
    end else if (w_lvl_nxt != r_lvl) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_target <= 1'b0;
      r_lvl    <= 1'b0;
      r_left   <= '0;
      r_seg    <= '0;
      r_tmr    <= '0;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_target <= w_target_nxt;
      r_lvl    <= w_lvl_nxt;
      r_left   <= w_left_nxt;
      r_seg    <= w_seg_nxt;
      r_tmr    <= w_tmr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_lvl          = r_lvl;
  assign o_busy         = (r_state != S_IDLE);
  assign o_toggle_count = r_cnt;
  assign o_state        = r_state;

endmodule
